// File: rtl/ble_resp_parser_pkg.sv
// Shared types and constants for the BLE AT-response parser and its UART neighbours.
package ble_resp_parser_pkg;

    // Response codes reported to the BLE control FSM
    typedef enum logic [2:0] {
        RESP_NONE     = 3'd0,
        RESP_OK       = 3'd1,
        RESP_ERROR    = 3'd2,
        RESP_CONN     = 3'd3,
        RESP_LOST     = 3'd4,
        RESP_UNKNOWN  = 3'd5,
        RESP_TIMEOUT  = 3'd6,
        RESP_OVERFLOW = 3'd7
    } resp_code_e;

    // Parser states
    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_CHECK   = 2'd1,
        S_REPORT  = 2'd2
    } state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Match strings are left-aligned: character i sits in byte (MATCH_MAX-1-i)
    localparam int unsigned MATCH_MAX = 8;
    localparam int unsigned OK_LEN    = 2;
    localparam int unsigned ERROR_LEN = 5;
    localparam int unsigned CONN_LEN  = 7;
    localparam int unsigned LOST_LEN  = 7;

    localparam logic [8*MATCH_MAX-1:0] STR_OK    = {"OK", 48'd0};
    localparam logic [8*MATCH_MAX-1:0] STR_ERROR = {"ERROR", 24'd0};
    localparam logic [8*MATCH_MAX-1:0] STR_CONN  = {"OK+CONN", 8'd0};
    localparam logic [8*MATCH_MAX-1:0] STR_LOST  = {"OK+LOST", 8'd0};

    // UART bit period at 50 MHz / 38400 baud, shared with the receiver and transmitter
    localparam int unsigned CYCLE_PER_BIT = 1302;

endpackage

// File: rtl/ble_line_buf.sv
// Line storage: byte buffer, character count and overflow flag for one response line.
module ble_line_buf
    import ble_resp_parser_pkg::*;
#(
    parameter int unsigned MAX_LINE = 16,
    parameter int unsigned LEN_W    = $clog2(MAX_LINE + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     clr,
    output logic [MAX_LINE-1:0][7:0] line_data,
    output logic [LEN_W-1:0]         len,
    output logic                     overflow
);

    localparam int unsigned IDX_W = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;

    // Length and overflow tracking; a byte arriving on a full line is dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            len      <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            len      <= '0;
            overflow <= 1'b0;
        end else if (wr_en) begin
            if (len == LEN_W'(MAX_LINE)) begin
                overflow <= 1'b1;
            end else begin
                len <= len + LEN_W'(1);
            end
        end
    end

    // Character storage; stale contents beyond len are never compared
    always_ff @(posedge clk) begin
        if (wr_en && !clr && (len != LEN_W'(MAX_LINE))) begin
            line_data[IDX_W'(len)] <= wr_data;
        end
    end

endmodule

// File: rtl/ble_resp_parser.sv
// Assembles UART bytes into CR/LF lines, classifies BLE AT responses, and times out silent modules.
module ble_resp_parser
    import ble_resp_parser_pkg::*;
#(
    parameter int unsigned MAX_LINE       = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_rx_data,
    input  logic       in_rx_valid,
    input  logic       in_arm,
    output logic       out_resp_valid,
    output logic [2:0] out_resp_code,
    output logic [4:0] out_line_len,
    output logic       out_busy
);

    localparam int unsigned LEN_W = $clog2(MAX_LINE + 1);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned IDX_W = (MAX_LINE > 1) ? $clog2(MAX_LINE) : 1;

    state_e                    state_q, state_d;
    logic                      armed_q, armed_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      resp_valid_d;
    resp_code_e                resp_code_d;
    logic [4:0]                line_len_d;
    resp_code_e                match_code;
    logic                      wr_en;
    logic                      clr;
    logic                      line_end;
    logic [MAX_LINE-1:0][7:0]  line_data;
    logic [LEN_W-1:0]          len;
    logic                      overflow;

    ble_line_buf #(
        .MAX_LINE (MAX_LINE),
        .LEN_W    (LEN_W)
    ) u_line_buf (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (in_rx_data),
        .clr       (clr),
        .line_data (line_data),
        .len       (len),
        .overflow  (overflow)
    );

    // Exact, full-length, case-sensitive comparison against a left-aligned match string
    function automatic logic match_str(input logic [MAX_LINE-1:0][7:0] data,
                                       input logic [LEN_W-1:0]         n,
                                       input logic [8*MATCH_MAX-1:0]   s,
                                       input int unsigned              slen);
        logic hit;
        hit = (n == LEN_W'(slen));
        for (int unsigned i = 0; i < MATCH_MAX; i++) begin
            if ((i < slen) && (data[IDX_W'(i)] != s[8*(MATCH_MAX-1-i) +: 8])) begin
                hit = 1'b0;
            end
        end
        return hit;
    endfunction

    // Line classifier; overflow overrides any textual match
    always_comb begin
        match_code = RESP_UNKNOWN;
        if (match_str(line_data, len, STR_OK, OK_LEN)) begin
            match_code = RESP_OK;
        end else if (match_str(line_data, len, STR_ERROR, ERROR_LEN)) begin
            match_code = RESP_ERROR;
        end else if (match_str(line_data, len, STR_CONN, CONN_LEN)) begin
            match_code = RESP_CONN;
        end else if (match_str(line_data, len, STR_LOST, LOST_LEN)) begin
            match_code = RESP_LOST;
        end
        if (overflow) begin
            match_code = RESP_OVERFLOW;
        end
    end

    // Next-state, timeout and report logic
    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        cnt_d        = cnt_q;
        resp_valid_d = 1'b0;
        resp_code_d  = resp_code_e'(out_resp_code);
        line_len_d   = out_line_len;
        wr_en        = 1'b0;
        clr          = 1'b0;
        line_end     = 1'b0;

        case (state_q)
            S_COLLECT: begin
                if (in_rx_valid) begin
                    if (in_rx_data == ASCII_LF) begin
                        if (len != '0) begin
                            line_end = 1'b1;
                            state_d  = S_CHECK;
                        end
                    end else if (in_rx_data != ASCII_CR) begin
                        wr_en = 1'b1;
                    end
                end
                if (armed_q) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // A completing line or a fresh arm pre-empts expiry
                    if ((cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) && !line_end && !in_arm) begin
                        resp_valid_d = 1'b1;
                        resp_code_d  = RESP_TIMEOUT;
                        line_len_d   = 5'd0;
                        armed_d      = 1'b0;
                    end
                end
            end
            S_CHECK: begin
                resp_valid_d = 1'b1;
                resp_code_d  = match_code;
                line_len_d   = 5'(len);
                state_d      = S_REPORT;
            end
            S_REPORT: begin
                clr     = 1'b1;
                armed_d = 1'b0;
                state_d = S_COLLECT;
            end
            default: begin
                state_d = S_COLLECT;
            end
        endcase

        // Arm last so an arm coinciding with a report is kept
        if (in_arm) begin
            armed_d = 1'b1;
            cnt_d   = '0;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_COLLECT;
            armed_q        <= 1'b0;
            cnt_q          <= '0;
            out_resp_valid <= 1'b0;
            out_resp_code  <= 3'd0;
            out_line_len   <= 5'd0;
        end else begin
            state_q        <= state_d;
            armed_q        <= armed_d;
            cnt_q          <= cnt_d;
            out_resp_valid <= resp_valid_d;
            out_resp_code  <= resp_code_d;
            out_line_len   <= line_len_d;
        end
    end

    assign out_busy = armed_q;

endmodule

// File: tb/tb_ble_resp_parser.sv
// Self-checking bench for ble_resp_parser: event-level model plus directed literal checks.
module tb_ble_resp_parser;

    localparam int T  = 100;
    localparam int ML = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_rx_data = 8'h00;
    logic       in_rx_valid = 1'b0;
    logic       in_arm = 1'b0;
    logic       out_resp_valid;
    logic [2:0] out_resp_code;
    logic [4:0] out_line_len;
    logic       out_busy;

    always #5 clk = ~clk;

    ble_resp_parser #(
        .MAX_LINE       (ML),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_rx_data     (in_rx_data),
        .in_rx_valid    (in_rx_valid),
        .in_arm         (in_arm),
        .out_resp_valid (out_resp_valid),
        .out_resp_code  (out_resp_code),
        .out_line_len   (out_line_len),
        .out_busy       (out_busy)
    );

    typedef struct {
        int cyc;
        int code;
        int len;
    } pulse_t;

    pulse_t exp_q[$];
    pulse_t log_q[$];
    byte    line_q[$];
    int     edge_cnt = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    bit     ovf_m = 1'b0;
    bit     armed_m = 1'b0;
    bit     line_done;
    int     deadline = -1;
    int     busy_clr = -1;
    int     hold_until = -1;
    int     last_edge = 0;
    int     last_arm = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    function automatic bit line_is(input string s);
        if (line_q.size() != s.len()) return 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            if (line_q[i] != s[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int classify();
        if (ovf_m)             return 7;
        if (line_is("OK"))      return 1;
        if (line_is("ERROR"))   return 2;
        if (line_is("OK+CONN")) return 3;
        if (line_is("OK+LOST")) return 4;
        return 5;
    endfunction

    // Event model: a line finished by an LF at edge E is reported after edge E+1;
    // an arm at edge A times out after edge A+T unless a line or re-arm intervenes.
    always @(posedge clk) begin
        edge_cnt++;
        if (rst) begin
            line_q.delete();
            exp_q.delete();
            ovf_m      = 1'b0;
            armed_m    = 1'b0;
            deadline   = -1;
            busy_clr   = -1;
            hold_until = -1;
        end else begin
            line_done = 1'b0;
            if (in_rx_valid) begin
                assert (edge_cnt > hold_until) else $error("byte strobe while a line is being reported");
                if (edge_cnt > hold_until) begin
                    if (in_rx_data == 8'h0A) begin
                        if (line_q.size() > 0) begin
                            exp_q.push_back('{edge_cnt + 1, classify(), line_q.size()});
                            line_q.delete();
                            ovf_m      = 1'b0;
                            hold_until = edge_cnt + 2;
                            line_done  = 1'b1;
                            if (armed_m) begin
                                deadline = -1;
                                busy_clr = edge_cnt + 2;
                            end
                        end
                    end else if (in_rx_data != 8'h0D) begin
                        if (line_q.size() < ML) line_q.push_back(byte'(in_rx_data));
                        else                    ovf_m = 1'b1;
                    end
                end
            end
            if (busy_clr == edge_cnt) begin
                armed_m  = 1'b0;
                busy_clr = -1;
            end
            if (in_arm) begin
                armed_m  = 1'b1;
                deadline = edge_cnt + T;
                busy_clr = -1;
            end else if (deadline == edge_cnt && !line_done) begin
                exp_q.push_back('{edge_cnt, 6, 0});
                armed_m  = 1'b0;
                deadline = -1;
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (edge_cnt > 0 && !rst) begin
            automatic bit exp_v = (exp_q.size() > 0) && (exp_q[0].cyc == edge_cnt);
            check("resp_valid", 32'(out_resp_valid), 32'(exp_v));
            if (exp_v) begin
                check("resp_code", 32'(out_resp_code), 32'(exp_q[0].code));
                check("line_len", 32'(out_line_len), 32'(exp_q[0].len));
                void'(exp_q.pop_front());
            end
            check("busy", 32'(out_busy), 32'(armed_m));
        end
    end

    // Pulse log used by the directed literal checks
    always @(negedge clk) begin
        if (edge_cnt > 0 && out_resp_valid === 1'b1) begin
            log_q.push_back('{edge_cnt, int'(out_resp_code), int'(out_line_len)});
        end
    end

    task automatic send_at(input logic [7:0] b, input int target);
        while (edge_cnt < target - 1) @(negedge clk);
        in_rx_data  = b;
        in_rx_valid = 1'b1;
        last_edge   = edge_cnt + 1;
        @(negedge clk);
        in_rx_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_at(b, edge_cnt + 1);
        repeat (19) @(negedge clk);
    endtask

    task automatic send_line(input string s, input bit with_cr);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        if (with_cr) send_byte(8'h0D);
        send_byte(8'h0A);
    endtask

    task automatic arm_at(input int target);
        while (edge_cnt < target - 1) @(negedge clk);
        in_arm   = 1'b1;
        last_arm = edge_cnt + 1;
        @(negedge clk);
        in_arm = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (edge_cnt < target) @(negedge clk);
    endtask

    task automatic expect_pulse(input string name, input int n0, input int cyc, input int code, input int len);
        check({name, "_count"}, 32'(log_q.size()), 32'(n0 + 1));
        if (log_q.size() > n0) begin
            check({name, "_cycle"}, 32'(log_q[n0].cyc), 32'(cyc));
            check({name, "_code"}, 32'(log_q[n0].code), 32'(code));
            check({name, "_len"}, 32'(log_q[n0].len), 32'(len));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got edge %0d, expected completion", edge_cnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n0;
        int a;
        int a2;
        int lf;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(out_resp_valid), 32'd0);
        check("rst_code", 32'(out_resp_code), 32'd0);
        check("rst_len", 32'(out_line_len), 32'd0);
        check("rst_busy", 32'(out_busy), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Basic OK with exact 2-cycle latency
        n0 = log_q.size();
        send_line("OK", 1'b1);
        expect_pulse("ok", n0, last_edge + 1, 1, 2);

        // Blank line is silent, then ERROR
        n0 = log_q.size();
        send_byte(8'h0D);
        send_byte(8'h0A);
        check("blank_silent", 32'(log_q.size()), 32'(n0));
        send_line("ERROR", 1'b1);
        expect_pulse("error", n0, last_edge + 1, 2, 5);

        n0 = log_q.size();
        send_line("OK+CONN", 1'b0);
        expect_pulse("conn", n0, last_edge + 1, 3, 7);

        n0 = log_q.size();
        send_line("OK+LOST", 1'b1);
        expect_pulse("lost", n0, last_edge + 1, 4, 7);

        n0 = log_q.size();
        send_line("HELLO", 1'b1);
        expect_pulse("hello", n0, last_edge + 1, 5, 5);

        // Near misses: prefix and wrong case
        n0 = log_q.size();
        send_line("OK+CON", 1'b1);
        expect_pulse("prefix", n0, last_edge + 1, 5, 6);
        n0 = log_q.size();
        send_line("ok", 1'b1);
        expect_pulse("lowercase", n0, last_edge + 1, 5, 2);

        // Overflow, then the flag is cleared for the next line
        n0 = log_q.size();
        for (int i = 0; i < 20; i++) send_byte(8'h41);
        send_byte(8'h0A);
        expect_pulse("overflow", n0, last_edge + 1, 7, 16);
        n0 = log_q.size();
        send_line("OK", 1'b1);
        expect_pulse("after_ovf", n0, last_edge + 1, 1, 2);

        // Exactly MAX_LINE characters is not an overflow
        n0 = log_q.size();
        for (int i = 0; i < 16; i++) send_byte(8'h42);
        send_byte(8'h0A);
        expect_pulse("full_line", n0, last_edge + 1, 5, 16);

        // Timeout with no response
        n0 = log_q.size();
        arm_at(edge_cnt + 1);
        a = last_arm;
        check("busy_armed", 32'(out_busy), 32'd1);
        wait_until(a + T + 20);
        expect_pulse("timeout", n0, a + T, 6, 0);
        check("busy_after_to", 32'(out_busy), 32'd0);

        // Re-arm restarts the count
        n0 = log_q.size();
        arm_at(edge_cnt + 1);
        a = last_arm;
        arm_at(a + 90);
        a2 = last_arm;
        wait_until(a2 + T + 20);
        expect_pulse("rearm", n0, a2 + T, 6, 0);

        // LF on the expiry edge: the line wins
        n0 = log_q.size();
        arm_at(edge_cnt + 1);
        a = last_arm;
        send_at(8'h4F, a + 60);
        send_at(8'h4B, a + 80);
        send_at(8'h0A, a + T);
        lf = last_edge;
        wait_until(a + T + 60);
        expect_pulse("race", n0, lf + 1, 1, 2);
        check("busy_after_race", 32'(out_busy), 32'd0);

        // Reset mid-line discards the partial line
        n0 = log_q.size();
        send_byte(8'h4F);
        send_byte(8'h4B);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        send_byte(8'h0A);
        repeat (5) @(negedge clk);
        check("rst_discard", 32'(log_q.size()), 32'(n0));
        send_line("OK", 1'b1);
        expect_pulse("after_rst", n0, last_edge + 1, 1, 2);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
